// File: rtl/dma_filter_pkg.sv
// Shared constants for the DMA read/write security filters.
package dma_filter_pkg;

    localparam logic [31:0] PROT_BASE_DEF = 32'hF520_6000;
    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam int          PAGE_SHIFT    = 12;

endpackage

// File: rtl/dma_rd_track_fifo.sv
// In-order DEPTH x 1-bit tracking FIFO holding the protected-hit flag of each outstanding read.
module dma_rd_track_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic full,
    output logic empty,
    output logic head
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_r;
    logic [PW:0]      rd_ptr_r;
    logic [DEPTH-1:0] mem_r;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign full  = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign head  = mem_r[rd_ptr_r[PW-1:0]];

    // Pointer and storage update; push and pop may both occur in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            mem_r    <= '0;
        end else begin
            if (push && !full) begin
                mem_r[wr_ptr_r[PW-1:0]] <= din;
                wr_ptr_r                <= wr_ptr_r + (PW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/dma_rd_resp_filter.sv
// DMA read-response filter: zeroes R data of reads aimed at the protected 4 KiB lock window.
// Optional macro DMA_RD_FILTER_SLVERR_EN: blocked and untracked beats also return SLVERR.
module dma_rd_resp_filter
    import dma_filter_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] PROT_BASE = ADDR_W'(PROT_BASE_DEF),
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ar_valid_i,
    output logic              ar_ready_o,
    input  logic [ADDR_W-1:0] ar_addr_i,
    output logic              ar_valid_o,
    input  logic              ar_ready_i,
    input  logic              r_valid_i,
    input  logic              r_ready_i,
    input  logic [DATA_W-1:0] r_data_i,
    input  logic [1:0]        r_resp_i,
    input  logic              r_last_i,
    output logic [DATA_W-1:0] r_data_o,
    output logic [1:0]        r_resp_o,
    output logic [CNT_W-1:0]  blocked_cnt_o,
    output logic              proto_err_o
);
    localparam logic [ADDR_W-1:0] PAGE_MASK = ~ADDR_W'((1 << PAGE_SHIFT) - 1);

    logic full_s;
    logic empty_s;
    logic head_s;
    logic hit_s;
    logic push_s;
    logic pop_s;
    logic r_hs_s;

    // Bursts never cross a 4 KiB page, so the start address decides the whole burst.
    assign hit_s  = (((ar_addr_i ^ PROT_BASE) & PAGE_MASK) == '0);
    assign ar_valid_o = ar_valid_i & ~full_s;
    assign ar_ready_o = ar_ready_i & ~full_s;
    assign push_s = ar_valid_o & ar_ready_i;
    assign r_hs_s = r_valid_i & r_ready_i;
    assign pop_s  = r_hs_s & r_last_i & ~empty_s;

    dma_rd_track_fifo #(
        .DEPTH (DEPTH)
    ) u_track (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (hit_s),
        .full  (full_s),
        .empty (empty_s),
        .head  (head_s)
    );

    // R masking: an untracked beat fails closed exactly like a protected one.
    always_comb begin
        r_data_o = r_data_i;
        r_resp_o = r_resp_i;
        if (empty_s || head_s) begin
            r_data_o = '0;
`ifdef DMA_RD_FILTER_SLVERR_EN
            r_resp_o = RESP_SLVERR;
`else
            r_resp_o = r_resp_i;
`endif
        end else begin
            r_data_o = r_data_i;
        end
    end

    // Saturating blocked-beat counter and sticky protocol-error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blocked_cnt_o <= '0;
            proto_err_o   <= 1'b0;
        end else begin
            if (r_hs_s && !empty_s && head_s && (blocked_cnt_o != '1)) begin
                blocked_cnt_o <= blocked_cnt_o + CNT_W'(1);
            end
            if (r_hs_s && empty_s) begin
                proto_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_rd_resp_filter.sv
// Self-checking bench for dma_rd_resp_filter: directed scenarios plus randomized traffic vs a queue model.
module tb_dma_rd_resp_filter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ar_valid_i, ar_ready_i, r_valid_i, r_ready_i, r_last_i;
    logic [31:0] ar_addr_i, r_data_i;
    logic [1:0]  r_resp_i;

    logic        ar_ready_o, ar_valid_o, proto_err_o;
    logic [31:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic [15:0] blocked_cnt_o;

    logic        s_ar_ready_o, s_ar_valid_o, s_proto_err_o;
    logic [31:0] s_r_data_o;
    logic [1:0]  s_r_resp_o;
    logic [1:0]  s_blocked_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    bit mq[$];
    int m_cnt;
    bit m_err;

    always #5 clk = ~clk;

    dma_rd_resp_filter #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_data_i(r_data_i),
        .r_resp_i(r_resp_i), .r_last_i(r_last_i),
        .r_data_o(r_data_o), .r_resp_o(r_resp_o),
        .blocked_cnt_o(blocked_cnt_o), .proto_err_o(proto_err_o)
    );

    dma_rd_resp_filter #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .ar_valid_i(ar_valid_i), .ar_ready_o(s_ar_ready_o), .ar_addr_i(ar_addr_i),
        .ar_valid_o(s_ar_valid_o), .ar_ready_i(ar_ready_i),
        .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_data_i(r_data_i),
        .r_resp_i(r_resp_i), .r_last_i(r_last_i),
        .r_data_o(s_r_data_o), .r_resp_o(s_r_resp_o),
        .blocked_cnt_o(s_blocked_cnt_o), .proto_err_o(s_proto_err_o)
    );

    // ---------------- reference model ----------------
    function automatic bit is_hit(input logic [31:0] a);
        return (a >> 12) == (32'hF520_6000 >> 12);
    endfunction

    function automatic bit m_full();
        return mq.size() == DEPTH;
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] d);
        if (mq.size() == 0 || mq[0]) return 32'h0;
        return d;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [1:0] r);
`ifdef DMA_RD_FILTER_SLVERR_EN
        if (mq.size() == 0 || mq[0]) return 2'b10;
`endif
        return r;
    endfunction

    function automatic logic [1:0] exp_sat();
        return (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    endfunction

    task automatic drive(input logic arv, input logic [31:0] addr, input logic arr,
                         input logic rv, input logic rr, input logic [31:0] rd,
                         input logic [1:0] rsp, input logic rl);
        ar_valid_i = arv; ar_addr_i = addr; ar_ready_i = arr;
        r_valid_i = rv; r_ready_i = rr; r_data_i = rd; r_resp_i = rsp; r_last_i = rl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    endtask

    // Advance one clock, updating the model from the inputs held during the cycle.
    task automatic tick();
        bit empty, hs, push;
        empty = (mq.size() == 0);
        hs    = r_valid_i && r_ready_i;
        push  = ar_valid_i && ar_ready_i && !m_full();
        if (hs && empty) m_err = 1'b1;
        if (hs && !empty && mq[0]) m_cnt++;
        if (hs && r_last_i && !empty) void'(mq.pop_front());
        if (push) mq.push_back(is_hit(ar_addr_i));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b1;
        mq.delete();
        m_cnt = 0;
        m_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One R beat with data/resp checks on both instances.
    task automatic beat(input string nm, input logic [31:0] d, input logic last);
        logic [1:0] rsp;
        rsp = 2'($urandom_range(0, 3));
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, d, rsp, last);
        n_checks++;
        if (r_data_o !== exp_data(d) || s_r_data_o !== exp_data(d))
            $display("FAIL %s data: got %h/%h expected %h", nm, r_data_o, s_r_data_o, exp_data(d));
        else n_pass++;
        n_checks++;
        if (r_resp_o !== exp_resp(rsp))
            $display("FAIL %s resp: got %b expected %b", nm, r_resp_o, exp_resp(rsp));
        else n_pass++;
        tick();
    endtask

    task automatic ar(input string nm, input logic [31:0] a);
        drive(1'b1, a, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
        n_checks++;
        if (ar_valid_o !== !m_full() || ar_ready_o !== !m_full())
            $display("FAIL %s ar: got v=%b r=%b expected %b", nm, ar_valid_o, ar_ready_o, !m_full());
        else n_pass++;
        tick();
    endtask

    task automatic check_counters(input string nm);
        n_checks++;
        if (blocked_cnt_o !== 16'(m_cnt) || s_blocked_cnt_o !== exp_sat())
            $display("FAIL %s cnt: got %0d/%0d expected %0d/%0d", nm, blocked_cnt_o,
                     s_blocked_cnt_o, m_cnt, exp_sat());
        else n_pass++;
        n_checks++;
        if (proto_err_o !== m_err || s_proto_err_o !== m_err)
            $display("FAIL %s proto_err: got %b expected %b", nm, proto_err_o, m_err);
        else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
        n_checks++;
        if (ar_valid_o !== 1'b0 || ar_ready_o !== 1'b1)
            $display("FAIL reset_ar: got v=%b r=%b expected v=0 r=1", ar_valid_o, ar_ready_o);
        else n_pass++;
        n_checks++;
        if (blocked_cnt_o !== 16'd0 || proto_err_o !== 1'b0)
            $display("FAIL reset_state: got cnt=%0d err=%b expected 0/0", blocked_cnt_o, proto_err_o);
        else n_pass++;
    endtask

    task automatic test_unprotected();
        ar("unprot", 32'hF520_0028);
        beat("unprot", 32'hDEAD_BEEF, 1'b1);
        n_checks++;
        if (blocked_cnt_o !== 16'd0)
            $display("FAIL unprot_cnt: got %0d expected 0", blocked_cnt_o);
        else n_pass++;
    endtask

    task automatic test_protected_burst();
        ar("prot", 32'hF520_6000);
        for (int i = 0; i < 4; i++) beat("prot", 32'h1234_5678, i == 3);
        n_checks++;
        if (blocked_cnt_o !== 16'd4)
            $display("FAIL prot_cnt: got %0d expected 4", blocked_cnt_o);
        else n_pass++;
        ar("prot_after", 32'h1000_0000);
        beat("prot_drained", 32'h0BAD_F00D, 1'b1);
        check_counters("prot");
    endtask

    task automatic test_interleaved();
        ar("inter0", 32'hF520_6010);
        ar("inter1", 32'h8000_0000);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5, 2'b00, 1'b1);
        n_checks++;
        if (r_data_o !== 32'h0) $display("FAIL inter_first: got %h expected 0", r_data_o);
        else n_pass++;
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h5A5A_5A5A, 2'b00, 1'b1);
        n_checks++;
        if (r_data_o !== 32'h5A5A_5A5A)
            $display("FAIL inter_second: got %h expected 5a5a5a5a", r_data_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_full_stall();
        for (int i = 0; i < DEPTH; i++) ar("fill", (i % 2 == 0) ? 32'hF520_6100 : 32'h2000_0040);
        drive(1'b1, 32'h3000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
        n_checks++;
        if (ar_valid_o !== 1'b0 || ar_ready_o !== 1'b0)
            $display("FAIL full_stall: got v=%b r=%b expected 0/0", ar_valid_o, ar_ready_o);
        else n_pass++;
        tick();
        drive(1'b1, 32'h3000_0000, 1'b1, 1'b1, 1'b1, 32'h1111_2222, 2'b00, 1'b1);
        n_checks++;
        if (ar_ready_o !== 1'b0)
            $display("FAIL full_no_bypass: got r=%b expected 0", ar_ready_o);
        else n_pass++;
        n_checks++;
        if (r_data_o !== exp_data(32'h1111_2222))
            $display("FAIL full_pop_data: got %h expected %h", r_data_o, exp_data(32'h1111_2222));
        else n_pass++;
        tick();
        ar("full_fifth", 32'h3000_0000);
        for (int i = 0; i < DEPTH; i++) beat("full_drain", $urandom, 1'b1);
        check_counters("full");
    endtask

    task automatic test_saturation();
        ar("sat", 32'hF520_6FFC);
        for (int i = 0; i < 5; i++) beat("sat", $urandom, i == 4);
        n_checks++;
        if (s_blocked_cnt_o !== 2'd3)
            $display("FAIL sat_cnt: got %0d expected 3", s_blocked_cnt_o);
        else n_pass++;
        check_counters("sat");
    endtask

    task automatic test_random();
        logic        arv, arr, rv, rr, rl;
        logic [31:0] a, d;
        logic [1:0]  rsp;
        for (int c = 0; c < 400; c++) begin
            arv = 1'($urandom);
            arr = 1'($urandom);
            a   = ($urandom_range(0, 1) == 0) ? (32'hF520_6000 | ($urandom & 32'hFFF)) : $urandom;
            rv  = (mq.size() != 0) && ($urandom_range(0, 2) != 0);
            rr  = 1'($urandom);
            rl  = ($urandom_range(0, 2) == 0);
            d   = $urandom;
            rsp = 2'($urandom_range(0, 3));
            drive(arv, a, arr, rv, rr, d, rsp, rl);
            n_checks++;
            if (ar_valid_o !== (arv && !m_full()) || ar_ready_o !== (arr && !m_full()))
                $display("FAIL rand_ar c=%0d: got v=%b r=%b expected v=%b r=%b", c, ar_valid_o,
                         ar_ready_o, arv && !m_full(), arr && !m_full());
            else n_pass++;
            if (rv && rr) begin
                n_checks++;
                if (r_data_o !== exp_data(d) || r_resp_o !== exp_resp(rsp))
                    $display("FAIL rand_r c=%0d: got %h/%b expected %h/%b", c, r_data_o, r_resp_o,
                             exp_data(d), exp_resp(rsp));
                else n_pass++;
            end
            tick();
            check_counters("rand");
        end
        idle();
        while (mq.size() != 0) beat("rand_drain", $urandom, 1'b1);
    endtask

    task automatic test_reset_midburst();
        apply_reset();
        ar("mid", 32'hF520_6040);
        beat("mid_pre", 32'hCAFE_0001, 1'b0);
        apply_reset();
        beat("mid_left0", 32'hCAFE_0002, 1'b0);
        check_counters("mid_left0");
        beat("mid_left1", 32'hCAFE_0003, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle();
            tick();
        end
        n_checks++;
        if (proto_err_o !== 1'b1) $display("FAIL mid_sticky: got %b expected 1", proto_err_o);
        else n_pass++;
        apply_reset();
        idle();
        n_checks++;
        if (proto_err_o !== 1'b0) $display("FAIL mid_clear: got %b expected 0", proto_err_o);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        test_reset();
        test_unprotected();
        test_protected_burst();
        test_interleaved();
        test_full_stall();
        test_saturation();
        test_random();
        test_reset_midburst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
